fnd_controller: RTL

FND_CONTROLLER -- requirements
Module: fnd_controller

---
 rtl/fnd_controller.sv | 103 ++++++++++
 1 files changed

// File: rtl/fnd_controller.sv
// Four-digit multiplexed seven-segment driver for a stopwatch/clock display.
// Shows sec.msec or hour.min; segment and digit-enable outputs are registered and active-low.
module fnd_controller #(
    parameter int unsigned SYS_CLK_HZ = 100_000_000,
    parameter int unsigned SCAN_HZ    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sel_mode,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    output logic [3:0] o_fnd_com,
    output logic [7:0] o_fnd_data
);

    localparam int unsigned DIV   = SYS_CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             scan_tick_c;

    logic [3:0] digit_c;
    logic       dp_c;
    logic [7:0] seg_c;
    logic [3:0] com_d;
    logic [7:0] data_d;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;  // out-of-range value shows a dash
        endcase
        return s;
    endfunction

    // Scan divider and digit index
    always_comb begin
        scan_tick_c = (cnt_q == CNT_W'(DIV - 1));
        cnt_d       = scan_tick_c ? '0 : cnt_q + CNT_W'(1);
        idx_d       = scan_tick_c ? idx_q + 2'd1 : idx_q;
    end

    // Digit value for the active position
    always_comb begin
        digit_c = 4'd0;
        if (!i_sel_mode) begin
            case (idx_q)
                2'd0:    digit_c = 4'(i_msec % 7'd10);
                2'd1:    digit_c = 4'(i_msec / 7'd10);
                2'd2:    digit_c = 4'(i_sec % 6'd10);
                default: digit_c = 4'(i_sec / 6'd10);
            endcase
        end else begin
            case (idx_q)
                2'd0:    digit_c = 4'(i_min % 6'd10);
                2'd1:    digit_c = 4'(i_min / 6'd10);
                2'd2:    digit_c = 4'(i_hour % 5'd10);
                default: digit_c = 4'(i_hour / 5'd10);
            endcase
        end
    end

    // Segment pattern, blinking dp and digit enable
    always_comb begin
        seg_c  = seg7(digit_c);
        dp_c   = (idx_q == 2'd2) && (i_msec < 7'd50);
        data_d = {seg_c[7] & ~dp_c, seg_c[6:0]};
        case (idx_q)
            2'd0:    com_d = 4'b1110;
            2'd1:    com_d = 4'b1101;
            2'd2:    com_d = 4'b1011;
            default: com_d = 4'b0111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            o_fnd_com  <= 4'b1111;
            o_fnd_data <= 8'hFF;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            o_fnd_com  <= com_d;
            o_fnd_data <= data_d;
        end
    end

endmodule
